collision_frame_detector: RTL and testbench
===========================================

COLLISION_FRAME_DETECTOR -- requirements
Module: collision_frame_detector

Interface
REQ-001 Parameter INVULN_FRAMES, default 30, frames during which player/monster-missile overlaps are ignored after an emitted collision0.
REQ-002 Parameter MIN_OVERLAP_PIXELS, default 4, overlap pixel threshold per frame; used only when MIN_OVERLAP_EN is defined.
REQ-003 clk  in  1  system clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 startOfFrame  in  1  one-cycle pulse that marks the frame boundary.
REQ-006 playerDR  in  1  player drawing request for the current pixel.
REQ-007 monsterDR  in  1  monster drawing request.
REQ-008 monsterMissileDR  in  1  monster missile drawing request.
REQ-009 playerMissileDR  in  1  player missile drawing request.
REQ-010 shieldDR  in  1  shield drawing request.
REQ-011 collision0  out  1  one-cycle pulse: player hit by a monster missile.
REQ-012 collision1  out  1  one-cycle pulse: player touched a monster.
REQ-013 collision2  out  1  one-cycle pulse: player missile hit a monster.
REQ-014 collision3  out  1  one-cycle pulse: monster reached a shield.
REQ-015 invulnerable  out  1  high while the invulnerability window is active.
REQ-016 hitCount  out  8  number of collision0 pulses emitted, saturating at 255.

Function
REQ-017 Overlap terms per cycle: ov0=playerDR&monsterMissileDR, ov1=playerDR&monsterDR, ov2=playerMissileDR&monsterDR, ov3=monsterDR&shieldDR.
REQ-018 Each ovN shall set sticky flag N for the current frame; the flag is cleared only at a frame boundary or by reset.
REQ-019 A cycle with startOfFrame=1 shall close the frame: the flags, including any ovN from that same cycle, are sampled and then cleared, so the next frame starts empty.
REQ-020 Each collisionN shall pulse high for exactly one cycle, on the cycle immediately after the closing startOfFrame, if flag N was set; at most one pulse per output per frame.
REQ-021 collision1 set in a frame shall suppress collision0 for that frame; collision1 and collision3 shall never be suppressed.
REQ-022 Invulnerability FSM states: ARMED and INVULN. Reset enters ARMED.
REQ-023 ARMED -> INVULN on the same edge that emits collision0, loading the frame counter with INVULN_FRAMES.
REQ-024 In INVULN the counter shall decrement on each startOfFrame; at 0 the FSM returns to ARMED; if INVULN_FRAMES=0, the FSM returns to ARMED at the next startOfFrame.
REQ-025 In INVULN, ov0 shall not set flag 0; invulnerable=1 exactly while in INVULN.
REQ-026 hitCount shall increment on every collision0 pulse and hold at 255.
REQ-027 Outputs shall be registered, with no combinational path from the DR inputs to any output.

Reset
REQ-028 While reset=1: all collisionN=0, invulnerable=0, hitCount=0, flags cleared, overlap counters cleared, FSM in ARMED, frame counter 0.
REQ-029 Reset mid-frame shall discard pending flags; no pulse is emitted at the next boundary for overlaps that occurred before reset.

Configuration
REQ-030 Macro MIN_OVERLAP_EN: when defined, each flag shall use a saturating pixel counter, and a flag is considered set only if its count is >= MIN_OVERLAP_PIXELS at frame close; counters clear at frame close.
REQ-031 When MIN_OVERLAP_EN is undefined, a single overlapping pixel shall set the flag and no counters shall be synthesized.

Verification
REQ-032 One cycle ov0 in frame N -> collision0=1 for exactly one cycle after the next startOfFrame; invulnerable=1; hitCount=1.
REQ-033 ov0 in the 5 frames following a hit (INVULN_FRAMES=30) -> no collision0; after 30 startOfFrame pulses, invulnerable=0; a new ov0 gives hitCount=2.
REQ-034 ov0 and ov1 in the same frame -> collision1 pulses and collision0 does not; hitCount unchanged.
REQ-035 ov3 asserted on the same cycle as startOfFrame -> collision3 pulses one cycle later; nothing is carried into the next frame.
REQ-036 ov2 in frame N, then reset pulsed before the frame boundary -> no collision2; all outputs are 0.
REQ-037 With MIN_OVERLAP_EN defined and MIN_OVERLAP_PIXELS=4: 3 ov0 pixels -> no pulse; 4 ov0 pixels -> collision0 pulse.

Source files
------------

// File: rtl/collision_frame_detector.sv
// Per-frame collision detector: latches sprite overlaps during a frame and reports them as
// one-cycle pulses after the closing startOfFrame. Optional macro MIN_OVERLAP_EN adds pixel-count thresholds.
module collision_frame_detector #(
  parameter int INVULN_FRAMES      = 30,
  parameter int MIN_OVERLAP_PIXELS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       playerDR,
  input  logic       monsterDR,
  input  logic       monsterMissileDR,
  input  logic       playerMissileDR,
  input  logic       shieldDR,
  output logic       collision0,
  output logic       collision1,
  output logic       collision2,
  output logic       collision3,
  output logic       invulnerable,
  output logic [7:0] hitCount
);

  typedef enum logic {ARMED, INVULN} inv_state_t;

  localparam int FCW = (INVULN_FRAMES < 2) ? 1 : $clog2(INVULN_FRAMES + 1);
  localparam logic [FCW-1:0] FRAMES_LOAD = FCW'(INVULN_FRAMES);

  inv_state_t     state;
  logic [FCW-1:0] frame_cnt;
  logic [3:0]     ov;
  logic [3:0]     ov_gated;
  logic [3:0]     frame_hits;
  logic           emit0;

  assign ov[0] = playerDR & monsterMissileDR;
  assign ov[1] = playerDR & monsterDR;
  assign ov[2] = playerMissileDR & monsterDR;
  assign ov[3] = monsterDR & shieldDR;

  // Missile hits on the player are ignored entirely while invulnerable.
  assign ov_gated = ov & {3'b111, (state == ARMED)};

`ifdef MIN_OVERLAP_EN
  localparam int CW = (MIN_OVERLAP_PIXELS < 1) ? 1 : $clog2(MIN_OVERLAP_PIXELS + 1);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_OVERLAP_PIXELS);

  logic [CW-1:0] cnt      [4];
  logic [CW-1:0] cnt_next [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = cnt[i];
      if (ov_gated[i] && (cnt[i] < MIN_C)) begin
        cnt_next[i] = cnt[i] + CW'(1);
      end
      frame_hits[i] = (cnt_next[i] >= MIN_C);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (reset || startOfFrame) begin
        cnt[i] <= '0;
      end else begin
        cnt[i] <= cnt_next[i];
      end
    end
  end
`else
  localparam int unused_min_overlap_pixels = MIN_OVERLAP_PIXELS;

  logic [3:0] flags;

  // The closing cycle's own overlaps count towards the frame being closed.
  assign frame_hits = flags | ov_gated;

  always_ff @(posedge clk) begin
    if (reset || startOfFrame) begin
      flags <= '0;
    end else begin
      flags <= frame_hits;
    end
  end
`endif

  assign emit0 = startOfFrame & frame_hits[0] & ~frame_hits[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      collision0   <= 1'b0;
      collision1   <= 1'b0;
      collision2   <= 1'b0;
      collision3   <= 1'b0;
      state        <= ARMED;
      invulnerable <= 1'b0;
      frame_cnt    <= '0;
      hitCount     <= '0;
    end else begin
      collision0 <= emit0;
      collision1 <= startOfFrame & frame_hits[1];
      collision2 <= startOfFrame & frame_hits[2];
      collision3 <= startOfFrame & frame_hits[3];

      if (emit0 && (hitCount != 8'hFF)) begin
        hitCount <= hitCount + 8'd1;
      end

      // The window counts the frame boundaries that follow the hit; a count of 0 or 1 ends at the next one.
      case (state)
        ARMED: begin
          if (emit0) begin
            state        <= INVULN;
            invulnerable <= 1'b1;
            frame_cnt    <= FRAMES_LOAD;
          end
        end
        INVULN: begin
          if (startOfFrame) begin
            if (frame_cnt <= FCW'(1)) begin
              state        <= ARMED;
              invulnerable <= 1'b0;
              frame_cnt    <= '0;
            end else begin
              frame_cnt <= frame_cnt - FCW'(1);
            end
          end
        end
        default: begin
          state        <= ARMED;
          invulnerable <= 1'b0;
          frame_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_frame_detector.sv
// Directed-vector bench for collision_frame_detector in its default build (MIN_OVERLAP_EN undefined).
module tb_collision_frame_detector;

  logic       clk;
  logic       reset;
  logic       startOfFrame;
  logic       playerDR;
  logic       monsterDR;
  logic       monsterMissileDR;
  logic       playerMissileDR;
  logic       shieldDR;
  logic       collision0;
  logic       collision1;
  logic       collision2;
  logic       collision3;
  logic       invulnerable;
  logic [7:0] hitCount;

  int checks = 0;
  int errors = 0;

  // Vector layout: {startOfFrame, player, monster, monsterMissile, playerMissile, shield}
  localparam logic [5:0] V_IDLE = 6'b000000;
  localparam logic [5:0] V_SOF  = 6'b100000;
  localparam logic [5:0] V_OV0  = 6'b010100;
  localparam logic [5:0] V_OV1  = 6'b011000;
  localparam logic [5:0] V_OV2  = 6'b001010;
  localparam logic [5:0] V_OV3  = 6'b001001;

  collision_frame_detector dut (
    .clk              (clk),
    .reset            (reset),
    .startOfFrame     (startOfFrame),
    .playerDR         (playerDR),
    .monsterDR        (monsterDR),
    .monsterMissileDR (monsterMissileDR),
    .playerMissileDR  (playerMissileDR),
    .shieldDR         (shieldDR),
    .collision0       (collision0),
    .collision1       (collision1),
    .collision2       (collision2),
    .collision3       (collision3),
    .invulnerable     (invulnerable),
    .hitCount         (hitCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, then sample just after the edge that consumed them.
  task automatic applyStimulus(input logic [5:0] v);
    {startOfFrame, playerDR, monsterDR, monsterMissileDR, playerMissileDR, shieldDR} = v;
    @(posedge clk);
    #1;
    {startOfFrame, playerDR, monsterDR, monsterMissileDR, playerMissileDR, shieldDR} = V_IDLE;
  endtask

  task automatic applyReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pulses();
    return {4'b0000, collision3, collision2, collision1, collision0};
  endfunction

  initial begin
    reset = 1'b1;
    {startOfFrame, playerDR, monsterDR, monsterMissileDR, playerMissileDR, shieldDR} = V_IDLE;
    @(posedge clk);
    #1;
    applyStimulus(V_OV0);
    applyStimulus(V_SOF);
    checkOutput("reset_pulses", pulses(), 8'h00);
    checkOutput("reset_invuln", {7'd0, invulnerable}, 8'h00);
    checkOutput("reset_hits", hitCount, 8'd0);
    reset = 1'b0;

    // Single ov0 pixel: collision0 after the boundary, invulnerability begins.
    applyStimulus(V_OV0);
    applyStimulus(V_IDLE);
    checkOutput("ov0_before_sof", pulses(), 8'h00);
    applyStimulus(V_SOF);
    checkOutput("hit_pulse", pulses(), 8'h01);
    checkOutput("hit_invuln", {7'd0, invulnerable}, 8'h01);
    checkOutput("hit_count1", hitCount, 8'd1);
    applyStimulus(V_IDLE);
    checkOutput("hit_one_cycle", pulses(), 8'h00);

    // Five frames of ov0 inside the window are ignored.
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(V_OV0);
      applyStimulus(V_SOF);
      checkOutput($sformatf("invuln_frame%0d", k), pulses(), 8'h00);
    end
    checkOutput("invuln_hits", hitCount, 8'd1);
    for (int k = 6; k <= 29; k++) applyStimulus(V_SOF);
    checkOutput("invuln_after29", {7'd0, invulnerable}, 8'h01);
    applyStimulus(V_SOF);
    checkOutput("invuln_after30", {7'd0, invulnerable}, 8'h00);
    applyStimulus(V_OV0);
    applyStimulus(V_SOF);
    checkOutput("rehit_pulse", pulses(), 8'h01);
    checkOutput("rehit_count2", hitCount, 8'd2);

    // Touching a monster in the same frame suppresses the missile hit.
    applyReset();
    applyStimulus(V_OV0);
    applyStimulus(V_OV1);
    applyStimulus(V_SOF);
    checkOutput("suppress_pulse", pulses(), 8'h02);
    checkOutput("suppress_hits", hitCount, 8'd0);
    checkOutput("suppress_invuln", {7'd0, invulnerable}, 8'h00);

    // Overlap on the closing cycle itself belongs to the closing frame only.
    applyStimulus(V_OV3 | V_SOF);
    checkOutput("sof_ov3_pulse", pulses(), 8'h08);
    applyStimulus(V_IDLE);
    applyStimulus(V_SOF);
    checkOutput("sof_ov3_no_carry", pulses(), 8'h00);

    // Several ov2 pixels give a single collision2 pulse.
    applyStimulus(V_OV2);
    applyStimulus(V_OV2);
    applyStimulus(V_SOF);
    checkOutput("ov2_pulse", pulses(), 8'h04);
    applyStimulus(V_IDLE);
    checkOutput("ov2_one_cycle", pulses(), 8'h00);

    // Reset mid-frame discards the pending ov2.
    applyStimulus(V_OV2);
    applyReset();
    applyStimulus(V_SOF);
    checkOutput("reset_discard_pulses", pulses(), 8'h00);
    checkOutput("reset_discard_hits", hitCount, 8'd0);
    checkOutput("reset_discard_invuln", {7'd0, invulnerable}, 8'h00);

    // hitCount saturates at 255; each hit waits out its 30-frame window.
    for (int h = 0; h < 255; h++) begin
      applyStimulus(V_OV0);
      applyStimulus(V_SOF);
      for (int k = 0; k < 30; k++) applyStimulus(V_SOF);
    end
    checkOutput("sat_count255", hitCount, 8'd255);
    applyStimulus(V_OV0);
    applyStimulus(V_SOF);
    checkOutput("sat_pulse", pulses(), 8'h01);
    checkOutput("sat_hold255", hitCount, 8'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
